alu_mc: RTL and testbench

Parametrised multi-cycle successor to the datapath ALU. Same 3-bit operation encoding, but operand width is a parameter, and operands are taken through a valid/ready handshake. Multiply and divide are iterative (one bit per cycle) instead of combinational. The result is held with ZF/CF/DZ flags until the consumer takes it. Sits in the execute stage between the register-read latch and write-back and stalls the pipeline via `in_ready`.

---
 rtl/alu_mc_if.sv | 26 ++
 rtl/alu_mc.sv | 166 ++++++++++++++++
 tb/tb_alu_mc.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Request/result bundle for alu_mc: operands in via valid/ready, result plus flags out via valid/ready.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       SEL;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] R;
    logic             ZF;
    logic             CF;
    logic             DZ;

    modport master (
        output in_valid, A, B, SEL, out_ready,
        input  in_ready, out_valid, R, ZF, CF, DZ
    );

    modport slave (
        input  in_valid, A, B, SEL, out_ready,
        output in_ready, out_valid, R, ZF, CF, DZ
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops land in DONE at the accept edge, mul/div iterate one bit per cycle.
// Accepts only in IDLE; the result is held in DONE until out_ready, so in_ready stays low meanwhile.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  io
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             zf_q, zf_d;
    logic             cf_q, cf_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_dif;
    logic [WIDTH-1:0] imm_res;
    logic             imm_cf;
    logic             is_iter;

    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_dif;
    logic             div_bit;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;

    assign add_sum = {1'b0, io.A} + {1'b0, io.B};
    assign sub_dif = {1'b0, io.A} - {1'b0, io.B};
    assign is_iter = (io.SEL == 3'd5) || ((io.SEL == 3'd6) && (io.B != '0));

    // Multiply: opa is the left-shifting multiplicand, opb the right-shifting multiplier.
    assign mul_acc = acc_q + (opb_q[0] ? opa_q : '0);

    // Divide: acc is the partial remainder, opa shifts the dividend out and the quotient in.
    assign rem_sh  = {acc_q, opa_q[WIDTH-1]};
    assign rem_dif = rem_sh - {1'b0, opb_q};
    assign div_bit = ~rem_dif[WIDTH];
    assign div_rem = div_bit ? rem_dif[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_quo = {opa_q[WIDTH-2:0], div_bit};

    always_comb begin
        imm_res = '0;
        imm_cf  = 1'b0;
        case (io.SEL)
            3'd0: begin
                imm_res = add_sum[WIDTH-1:0];
                imm_cf  = add_sum[WIDTH];
            end
            3'd1: begin
                imm_res = sub_dif[WIDTH-1:0];
                imm_cf  = sub_dif[WIDTH];
            end
            3'd2:    imm_res = io.A & io.B;
            3'd3:    imm_res = io.A | io.B;
            3'd4:    imm_res = {{(WIDTH-1){1'b0}}, (io.A < io.B)};
            3'd6:    imm_res = '1;
            default: imm_res = io.B;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        r_d     = r_q;
        zf_d    = zf_q;
        cf_d    = cf_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (io.in_valid) begin
                    if (is_iter) begin
                        state_d = (io.SEL == 3'd5) ? S_MUL : S_DIV;
                        cnt_d   = CW'(WIDTH);
                        opa_d   = io.A;
                        opb_d   = io.B;
                        acc_d   = '0;
                    end else begin
                        state_d = S_DONE;
                        r_d     = imm_res;
                        zf_d    = (imm_res == '0);
                        cf_d    = imm_cf;
                        dz_d    = (io.SEL == 3'd6);
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_acc;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    r_d     = mul_acc;
                    zf_d    = (mul_acc == '0);
                    cf_d    = 1'b0;
                    dz_d    = 1'b0;
                end
            end
            S_DIV: begin
                acc_d = div_rem;
                opa_d = div_quo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    r_d     = div_quo;
                    zf_d    = (div_quo == '0);
                    cf_d    = 1'b0;
                    dz_d    = 1'b0;
                end
            end
            S_DONE: begin
                if (io.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            r_q     <= '0;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            r_q     <= r_d;
            zf_q    <= zf_d;
            cf_q    <= cf_d;
            dz_q    <= dz_d;
        end
    end

    assign io.in_ready  = (state_q == S_IDLE);
    assign io.out_valid = (state_q == S_DONE);
    assign io.R         = r_q;
    assign io.ZF        = zf_q;
    assign io.CF        = cf_q;
    assign io.DZ        = dz_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: fixed vectors, hand-written handshake/reset sequences and random ops on 32- and 8-bit instances.
module tb_alu_mc;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_mc_if #(.WIDTH(32)) b32 ();
    alu_mc_if #(.WIDTH(8))  b8 ();

    alu_mc #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .io(b32.slave));
    alu_mc #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .io(b8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
        logic [31:0] r;
        logic        zf;
        logic        cf;
        logic        dz;
        int          lat;
        bit          toggle;
        int          hold;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] s);
        if (w == 8) begin
            b8.in_valid = v; b8.A = a[7:0]; b8.B = b[7:0]; b8.SEL = s;
        end else begin
            b32.in_valid = v; b32.A = a; b32.B = b; b32.SEL = s;
        end
    endtask

    task automatic set_ordy(input int w, input logic v);
        if (w == 8) b8.out_ready = v;
        else        b32.out_ready = v;
    endtask

    task automatic rd(input int w, output logic ov, output logic ir, output logic [31:0] r,
                      output logic zf, output logic cf, output logic dz);
        if (w == 8) begin
            ov = b8.out_valid; ir = b8.in_ready; r = {24'd0, b8.R};
            zf = b8.ZF; cf = b8.CF; dz = b8.DZ;
        end else begin
            ov = b32.out_valid; ir = b32.in_ready; r = b32.R;
            zf = b32.ZF; cf = b32.CF; dz = b32.DZ;
        end
    endtask

    // Reference: plain wide arithmetic on w-bit unsigned operands.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                         output logic [31:0] r, output logic zf, output logic cf, output logic dz,
                         output int lat);
        longint unsigned mask, ua, ub, x;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & mask;
        ub = {32'd0, b} & mask;
        cf = 1'b0; dz = 1'b0; lat = 1; x = 0;
        case (s)
            3'd0: begin x = ua + ub; cf = (x > mask); x = x & mask; end
            3'd1: begin x = (ua - ub) & mask; cf = (ua < ub); end
            3'd2: x = ua & ub;
            3'd3: x = ua | ub;
            3'd4: x = (ua < ub) ? 1 : 0;
            3'd5: begin x = (ua * ub) & mask; lat = w + 1; end
            3'd6: begin
                if (ub == 0) begin x = mask; dz = 1'b1; end
                else begin x = ua / ub; lat = w + 1; end
            end
            default: x = ub;
        endcase
        r  = x[31:0];
        zf = (x == 0);
    endtask

    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                         input logic [31:0] er, input logic ezf, input logic ecf, input logic edz,
                         input int elat, input bit toggle, input int hold, input bit rel,
                         input string tag);
        logic ov, ir, zf, cf, dz;
        logic [31:0] r;
        logic [31:0] held;
        int lat;
        int guard;
        guard = 0;
        rd(w, ov, ir, r, zf, cf, dz);
        while (!ir && guard < 100) begin
            @(negedge clk);
            guard++;
            rd(w, ov, ir, r, zf, cf, dz);
        end
        if (!ir) check({tag, " in_ready timeout"}, {31'd0, ir}, 32'd1);
        drive(w, 1'b1, a, b, s);
        @(negedge clk);
        drive(w, 1'b0, a, b, s);
        lat = 1;
        rd(w, ov, ir, r, zf, cf, dz);
        while (!ov && lat < 100) begin
            if (toggle) drive(w, 1'b0, $urandom, $urandom, 3'($urandom_range(7)));
            @(negedge clk);
            lat++;
            rd(w, ov, ir, r, zf, cf, dz);
        end
        check({tag, " out_valid"}, {31'd0, ov}, 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " R"}, r, er);
        check({tag, " ZF"}, {31'd0, zf}, {31'd0, ezf});
        check({tag, " CF"}, {31'd0, cf}, {31'd0, ecf});
        check({tag, " DZ"}, {31'd0, dz}, {31'd0, edz});
        held = r;
        for (int h = 0; h < hold; h++) begin
            drive(w, 1'b0, $urandom, $urandom, 3'($urandom_range(7)));
            @(negedge clk);
            rd(w, ov, ir, r, zf, cf, dz);
            check({tag, " held R"}, r, held);
            check({tag, " held out_valid"}, {31'd0, ov}, 32'd1);
        end
        if (rel) begin
            set_ordy(w, 1'b1);
            @(negedge clk);
            set_ordy(w, 1'b0);
            rd(w, ov, ir, r, zf, cf, dz);
            check({tag, " out_valid after take"}, {31'd0, ov}, 32'd0);
            check({tag, " R kept after take"}, r, held);
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic ov, ir, zf, cf, dz, ezf, ecf, edz;
        logic [31:0] r, er, a, b;
        logic [2:0] s;
        int elat, w, seen;

        vecs.push_back('{32, 32'hFFFF_FFFF, 32'h1,         3'd0, 32'h0,         1, 1, 0, 1,  0, 0});
        vecs.push_back('{32, 32'h3,         32'h5,         3'd1, 32'hFFFF_FFFE, 0, 1, 0, 1,  0, 4});
        vecs.push_back('{32, 32'h0001_0001, 32'h0001_0003, 3'd5, 32'h0004_0003, 0, 0, 0, 33, 1, 0});
        vecs.push_back('{32, 32'd100,       32'd7,         3'd6, 32'd14,        0, 0, 0, 33, 1, 0});
        vecs.push_back('{32, 32'd5,         32'd0,         3'd6, 32'hFFFF_FFFF, 0, 0, 1, 1,  0, 0});
        vecs.push_back('{8,  32'h10,        32'h20,        3'd5, 32'h0,         1, 0, 0, 9,  1, 0});
        vecs.push_back('{8,  32'd2,         32'd9,         3'd4, 32'd1,         0, 0, 0, 1,  0, 0});
        vecs.push_back('{32, 32'h1234,      32'h55,        3'd7, 32'h55,        0, 0, 0, 1,  0, 0});
        vecs.push_back('{32, 32'hF0F0_1234, 32'h0FF0_FF00, 3'd2, 32'h00F0_1200, 0, 0, 0, 1,  0, 0});
        vecs.push_back('{32, 32'hA000_0000, 32'h5,         3'd3, 32'hA000_0005, 0, 0, 0, 1,  0, 0});
        vecs.push_back('{32, 32'd9,         32'd2,         3'd4, 32'd0,         1, 0, 0, 1,  0, 0});
        vecs.push_back('{8,  32'hFF,        32'h01,        3'd0, 32'h0,         1, 1, 0, 1,  0, 0});
        vecs.push_back('{8,  32'hFF,        32'h03,        3'd6, 32'h55,        0, 0, 0, 9,  1, 0});
        vecs.push_back('{32, 32'd5,         32'd5,         3'd1, 32'd0,         1, 0, 0, 1,  0, 0});

        rst = 1'b1;
        drive(32, 1'b0, 0, 0, 3'd0);
        drive(8, 1'b0, 0, 0, 3'd0);
        set_ordy(32, 1'b0);
        set_ordy(8, 1'b0);
        repeat (2) @(negedge clk);
        rd(32, ov, ir, r, zf, cf, dz);
        check("reset in_ready", {31'd0, ir}, 32'd1);
        check("reset out_valid", {31'd0, ov}, 32'd0);
        check("reset R", r, 32'd0);
        check("reset flags", {29'd0, zf, cf, dz}, 32'd0);
        rd(8, ov, ir, r, zf, cf, dz);
        check("reset8 R/valid", {r[30:0], ov}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].r, vecs[i].zf, vecs[i].cf,
                  vecs[i].dz, vecs[i].lat, vecs[i].toggle, vecs[i].hold, 1'b1, $sformatf("vec%0d", i));
        end

        // Reset while a result is held in DONE clears it.
        do_op(32, 32'd3, 32'd5, 3'd1, 32'hFFFF_FFFE, 0, 1, 0, 1, 0, 1, 1'b0, "sub held");
        #2 rst = 1'b1;
        #1 rd(32, ov, ir, r, zf, cf, dz);
        check("rst in DONE out_valid", {31'd0, ov}, 32'd0);
        check("rst in DONE R", r, 32'd0);
        check("rst in DONE flags", {29'd0, zf, cf, dz}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // out_ready and in_valid together in DONE: only the take completes.
        do_op(32, 32'd7, 32'd8, 3'd0, 32'd15, 0, 0, 0, 1, 0, 0, 1'b0, "add pre-overlap");
        drive(32, 1'b1, 32'd20, 32'd22, 3'd0);
        set_ordy(32, 1'b1);
        @(negedge clk);
        set_ordy(32, 1'b0);
        rd(32, ov, ir, r, zf, cf, dz);
        check("overlap out_valid", {31'd0, ov}, 32'd0);
        check("overlap in_ready", {31'd0, ir}, 32'd1);
        @(negedge clk);
        drive(32, 1'b0, 32'd0, 32'd0, 3'd0);
        rd(32, ov, ir, r, zf, cf, dz);
        check("overlap second out_valid", {31'd0, ov}, 32'd1);
        check("overlap second R", r, 32'd42);
        set_ordy(32, 1'b1);
        @(negedge clk);
        set_ordy(32, 1'b0);

        // Reset ten cycles into a divide aborts it.
        drive(32, 1'b1, 32'd1000, 32'd3, 3'd6);
        @(negedge clk);
        drive(32, 1'b0, 32'd1000, 32'd3, 3'd6);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1 rd(32, ov, ir, r, zf, cf, dz);
        check("rst mid-div in_ready", {31'd0, ir}, 32'd1);
        check("rst mid-div out_valid", {31'd0, ov}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rd(32, ov, ir, r, zf, cf, dz);
            if (ov) seen++;
        end
        check("aborted div never valid", 32'(seen), 32'd0);
        do_op(32, 32'd0, 32'h55, 3'd7, 32'h55, 0, 0, 0, 1, 0, 0, 1'b1, "pass after abort");

        for (int i = 0; i < 150; i++) begin
            w = ($urandom_range(1) == 0) ? 8 : 32;
            a = $urandom;
            b = ($urandom_range(5) == 0) ? 32'd0 : $urandom;
            if (w == 8 && $urandom_range(1) == 1) b = b & 32'hF;
            s = 3'($urandom_range(7));
            model(w, a, b, s, er, ezf, ecf, edz, elat);
            do_op(w, a, b, s, er, ezf, ecf, edz, elat, 1'($urandom_range(1)), $urandom_range(2), 1'b1,
                  $sformatf("rand%0d w%0d sel%0d", i, w, s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
